// File: rtl/enigma_pkg.sv
// enigma_pkg: shared widths, state codes and output-buffer entry type for the
// enigma_ctrl sequencer and its FIFO.
package enigma_pkg;

    localparam int TABLE_SIZE = 64;
    localparam int SYM_W      = 6;
    localparam int IDX_W      = 8;

    localparam logic [IDX_W-1:0] IDX_NONE = 8'hFF;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t CRST  = 3'd1;
    localparam state_t PRIME = 3'd2;
    localparam state_t LOAD  = 3'd3;
    localparam state_t ARM   = 3'd4;
    localparam state_t CRYPT = 3'd5;
    localparam state_t DRAIN = 3'd6;

    typedef struct packed {
        logic             last;
        logic [SYM_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/enigma_ctrl_if.sv
// enigma_ctrl_if: host-side symbol stream (input and output valid/ready
// channels) between the host and the enigma_ctrl sequencer.
interface enigma_ctrl_if;
    import enigma_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [SYM_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/enigma_ctrl_fifo.sv
// enigma_ctrl_fifo: small synchronous FIFO holding {last,data} ciphertext
// entries. Push and pop may happen together at any occupancy; the caller
// guarantees no push when full and no pop when empty.
module enigma_ctrl_fifo
    import enigma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srstn,
    input  logic                     push,
    input  fifo_entry_t              push_entry,
    input  logic                     pop,
    output fifo_entry_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Storage array: written on push, no reset needed since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/enigma_ctrl.sv
// enigma_ctrl: sequencer in front of the single-rotor enigma core. Each new
// message resets the core, streams the 64-entry rotor table into it, then
// passes plaintext through it and buffers ciphertext for the host.
// Optional feature macro: ENIGMA_CTRL_PERM_CHECK_EN (rotor table permutation
// check; a repeated table value sets perm_err and aborts the message in ARM).
module enigma_ctrl
    import enigma_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              cfg_start,
    input  logic              cfg_mode,
    enigma_ctrl_if.slave      host,
    output logic              busy,
    output logic              perm_err,
    output logic              core_srstn,
    output logic              core_load,
    output logic [IDX_W-1:0]  core_load_idx,
    output logic [SYM_W-1:0]  core_code_in,
    output logic              core_encrypt,
    output logic              core_crypt_mode,
    input  logic [SYM_W-1:0]  core_code_out,
    input  logic              core_code_valid
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SYM_W-1:0] LAST_IDX = SYM_W'(TABLE_SIZE - 1);

    state_t            state;
    state_t            state_n;
    logic [SYM_W-1:0]  load_cnt;
    logic              inflight;
    logic              inflight_last;
    logic              mode_q;
    logic              in_accept;
    logic              credit_ok;
    logic [CNT_W:0]    credit_used;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    fifo_entry_t       fifo_in;
    fifo_entry_t       fifo_head;

    // Symbols in the core pipeline count against buffer space so the FIFO can never overflow.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);
    assign in_accept   = host.in_valid & host.in_ready;

    // Input readiness: every cycle in LOAD, credit-limited in CRYPT, closed otherwise.
    always_comb begin
        host.in_ready = 1'b0;
        case (state)
            LOAD:    host.in_ready = 1'b1;
            CRYPT:   host.in_ready = credit_ok;
            default: host.in_ready = 1'b0;
        endcase
    end

    // Message sequencing: reset core, prime, load table, arm, crypt, drain.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cfg_start) state_n = CRST;
            CRST:    state_n = PRIME;
            PRIME:   state_n = LOAD;
            LOAD:    if (in_accept && load_cnt == LAST_IDX) state_n = ARM;
            ARM:     state_n = perm_err ? IDLE : CRYPT;
            CRYPT:   if (in_accept && host.in_last) state_n = DRAIN;
            DRAIN:   if (!inflight && fifo_empty) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register plus the registered core reset, which follows the next state.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state      <= IDLE;
            core_srstn <= 1'b0;
        end else begin
            state      <= state_n;
            core_srstn <= (state_n != CRST);
        end
    end

    // Table beat counter, message mode latch and the one-deep core pipeline tag.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            load_cnt      <= '0;
            mode_q        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= core_encrypt;
            inflight_last <= core_encrypt & host.in_last;
            if (state == IDLE && cfg_start) begin
                mode_q <= cfg_mode;
            end
            if (state == CRST) begin
                load_cnt <= '0;
            end else if (state == LOAD && in_accept) begin
                load_cnt <= load_cnt + SYM_W'(1);
            end
        end
    end

`ifdef ENIGMA_CTRL_PERM_CHECK_EN
    logic [TABLE_SIZE-1:0] seen;

    // Duplicate-value detector over the table beats; perm_err is sticky until the next start.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            seen     <= '0;
            perm_err <= 1'b0;
        end else begin
            if (state == IDLE && cfg_start) begin
                perm_err <= 1'b0;
            end
            if (state == PRIME) begin
                seen <= '0;
            end else if (state == LOAD && in_accept) begin
                if (seen[host.in_data]) begin
                    perm_err <= 1'b1;
                end
                seen[host.in_data] <= 1'b1;
            end
        end
    end
`else
    assign perm_err = 1'b0;
`endif

    assign busy            = (state != IDLE);
    assign core_load       = (state == PRIME) || (state == LOAD);
    assign core_load_idx   = (state == LOAD && in_accept) ? {2'b00, load_cnt} : IDX_NONE;
    assign core_code_in    = in_accept ? host.in_data : '0;
    assign core_encrypt    = (state == CRYPT) && in_accept;
    assign core_crypt_mode = mode_q;

    // A core result without a symbol in flight is a protocol error and is dropped.
    assign fifo_push      = core_code_valid & inflight;
    assign fifo_in.last   = inflight_last;
    assign fifo_in.data   = core_code_out;
    assign fifo_pop       = !fifo_empty && host.out_ready;

    assign host.out_valid = !fifo_empty;
    assign host.out_data  = fifo_head.data;
    assign host.out_last  = !fifo_empty && fifo_head.last;

    enigma_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .srstn      (srstn),
        .push       (fifo_push),
        .push_entry (fifo_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

endmodule
